// File: rtl/segre_mem_arbiter.sv
// ---------------------------------------------------------------------------
// segre_mem_arbiter
// Shares the single main-memory port between the icache and dcache miss
// paths. Each grant is sequenced writeback (dcache only, when the victim lane
// is dirty) -> lane fill -> one-cycle ready pulse back to the winning cache.
// Simultaneous requests are granted round-robin.
//
// Ports
//   clk_i, rst_i                       clock, synchronous active-high reset
//   ic_miss_i / ic_addr_i              icache fill request (level-held)
//   ic_rdy_o / ic_data_o / ic_addr_o   icache fill response (1-cycle pulse)
//   dc_miss_i / dc_addr_i              dcache fill request (level-held)
//   dc_writeback_i / dc_wb_addr_i /
//   dc_wb_data_i                       dirty victim lane to write back first
//   dc_rdy_o / dc_data_o / dc_addr_o   dcache fill response (1-cycle pulse)
//   mem_req_o / mem_we_o /
//   mem_addr_o / mem_data_o            memory request, held until mem_ack_i
//   mem_ack_i / mem_data_i             memory completion and read data
//   busy_o                             a transaction is in progress
//   err_o                              sticky: an ack wait reached TIMEOUT
// ---------------------------------------------------------------------------
module segre_mem_arbiter #(
    parameter int ADDR_SIZE = 32,
    parameter int LANE_SIZE = 128,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 ic_miss_i,
    input  logic [ADDR_SIZE-1:0] ic_addr_i,
    output logic                 ic_rdy_o,
    output logic [LANE_SIZE-1:0] ic_data_o,
    output logic [ADDR_SIZE-1:0] ic_addr_o,
    input  logic                 dc_miss_i,
    input  logic [ADDR_SIZE-1:0] dc_addr_i,
    input  logic                 dc_writeback_i,
    input  logic [ADDR_SIZE-1:0] dc_wb_addr_i,
    input  logic [LANE_SIZE-1:0] dc_wb_data_i,
    output logic                 dc_rdy_o,
    output logic [LANE_SIZE-1:0] dc_data_o,
    output logic [ADDR_SIZE-1:0] dc_addr_o,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [ADDR_SIZE-1:0] mem_addr_o,
    output logic [LANE_SIZE-1:0] mem_data_o,
    input  logic                 mem_ack_i,
    input  logic [LANE_SIZE-1:0] mem_data_i,
    output logic                 busy_o,
    output logic                 err_o
);

    localparam int OFS   = $clog2(LANE_SIZE / 8);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WB   = 2'd1;
    localparam logic [1:0] RD   = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    localparam logic IC = 1'b0;
    localparam logic DC = 1'b1;

    localparam logic [ADDR_SIZE-1:0] LANE_MASK = {{(ADDR_SIZE - OFS){1'b1}}, {OFS{1'b0}}};
    localparam logic [CNT_W-1:0]     CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]     CNT_LIMIT = CNT_W'(TIMEOUT);

    logic [1:0]           state;
    logic                 last_grant;
    logic                 grant;
    logic [ADDR_SIZE-1:0] fill_addr;
    logic [ADDR_SIZE-1:0] wb_addr;
    logic [LANE_SIZE-1:0] wb_data;
    logic [LANE_SIZE-1:0] rd_data;
    logic [CNT_W-1:0]     wait_cnt;
    logic [CNT_W-1:0]     wait_cnt_next;
    logic                 err;
    logic                 waiting;
    logic                 pick_dc;

    // The dcache wins when it is the only requester, or when both request
    // and the icache had the previous grant.
    assign pick_dc = dc_miss_i && (!ic_miss_i || last_grant == IC);
    assign waiting = (state == WB) || (state == RD);

    // Main sequencer. Requests and victim data are captured only at grant;
    // later changes on the request inputs do not affect the transaction.
    // The victim lane is captured only when it will actually be written, so
    // mem_data_o stays stable across transactions that only read.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            last_grant <= IC;
            grant      <= IC;
            fill_addr  <= '0;
            wb_addr    <= '0;
            wb_data    <= '0;
            rd_data    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ic_miss_i || dc_miss_i) begin
                        grant      <= pick_dc;
                        last_grant <= pick_dc;
                        if (pick_dc) begin
                            fill_addr <= dc_addr_i & LANE_MASK;
                            if (dc_writeback_i) begin
                                wb_addr <= dc_wb_addr_i & LANE_MASK;
                                wb_data <= dc_wb_data_i;
                                state   <= WB;
                            end else begin
                                state   <= RD;
                            end
                        end else begin
                            fill_addr <= ic_addr_i & LANE_MASK;
                            state     <= RD;
                        end
                    end
                end
                WB: begin
                    if (mem_ack_i) begin
                        state <= RD;
                    end
                end
                RD: begin
                    if (mem_ack_i) begin
                        rd_data <= mem_data_i;
                        state   <= RESP;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Saturating count of cycles spent waiting for the current ack.
    assign wait_cnt_next = (wait_cnt == CNT_MAX) ? wait_cnt : wait_cnt + CNT_W'(1);

    // The counter is zero whenever a wait starts because it is cleared in
    // IDLE/RESP and by the ack that moves WB into RD. The error flag stays
    // set until reset; the sequencer keeps waiting regardless.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wait_cnt <= '0;
            err      <= 1'b0;
        end else if (!waiting || mem_ack_i) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt_next;
            if (wait_cnt_next == CNT_LIMIT) begin
                err <= 1'b1;
            end
        end
    end

    assign mem_req_o  = waiting;
    assign mem_we_o   = (state == WB);
    assign mem_addr_o = (state == WB) ? wb_addr : fill_addr;
    assign mem_data_o = wb_data;

    assign ic_rdy_o   = (state == RESP) && (grant == IC);
    assign dc_rdy_o   = (state == RESP) && (grant == DC);
    assign ic_data_o  = rd_data;
    assign dc_data_o  = rd_data;
    assign ic_addr_o  = fill_addr;
    assign dc_addr_o  = fill_addr;

    assign busy_o     = (state != IDLE);
    assign err_o      = err;

endmodule

// File: tb/tb_segre_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_segre_mem_arbiter
// Self-checking bench for segre_mem_arbiter. A transaction-level reference
// model (pending requester levels, round-robin pick, a queue of expected
// memory operations, a lane memory and a wait counter) predicts every output
// each cycle. Directed scenarios are followed by randomized traffic.
// ---------------------------------------------------------------------------
module tb_segre_mem_arbiter;

    localparam int ADDR   = 32;
    localparam int LANE   = 128;
    localparam int TMO    = 255;
    localparam logic [31:0] ALIGN = 32'hFFFF_FFF0;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic             ic_miss_i = 1'b0;
    logic [ADDR-1:0]  ic_addr_i = '0;
    logic             ic_rdy_o;
    logic [LANE-1:0]  ic_data_o;
    logic [ADDR-1:0]  ic_addr_o;
    logic             dc_miss_i = 1'b0;
    logic [ADDR-1:0]  dc_addr_i = '0;
    logic             dc_writeback_i = 1'b0;
    logic [ADDR-1:0]  dc_wb_addr_i = '0;
    logic [LANE-1:0]  dc_wb_data_i = '0;
    logic             dc_rdy_o;
    logic [LANE-1:0]  dc_data_o;
    logic [ADDR-1:0]  dc_addr_o;
    logic             mem_req_o;
    logic             mem_we_o;
    logic [ADDR-1:0]  mem_addr_o;
    logic [LANE-1:0]  mem_data_o;
    logic             mem_ack_i = 1'b0;
    logic [LANE-1:0]  mem_data_i = '0;
    logic             busy_o;
    logic             err_o;

    segre_mem_arbiter #(.ADDR_SIZE(ADDR), .LANE_SIZE(LANE), .TIMEOUT(TMO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ic_miss_i(ic_miss_i), .ic_addr_i(ic_addr_i),
        .ic_rdy_o(ic_rdy_o), .ic_data_o(ic_data_o), .ic_addr_o(ic_addr_o),
        .dc_miss_i(dc_miss_i), .dc_addr_i(dc_addr_i),
        .dc_writeback_i(dc_writeback_i), .dc_wb_addr_i(dc_wb_addr_i), .dc_wb_data_i(dc_wb_data_i),
        .dc_rdy_o(dc_rdy_o), .dc_data_o(dc_data_o), .dc_addr_o(dc_addr_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
        .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit              we;
        logic [ADDR-1:0] addr;
        logic [LANE-1:0] data;
    } mem_op_t;

    int vec_count  = 0;
    int miss_count = 0;

    // Reference model state
    bit              m_busy = 0;
    bit              m_resp = 0;
    bit              m_who  = 0;
    bit              m_last = 0;
    bit              m_err  = 0;
    int              m_wait = 0;
    logic [ADDR-1:0] m_fill = '0;
    logic [LANE-1:0] m_data = '0;
    mem_op_t         m_ops[$];
    logic [LANE-1:0] mem[logic [ADDR-1:0]];

    // Stimulus controls
    int ack_mode    = 1;
    bit random_mode = 0;
    int ic_pct      = 0;
    int dc_pct      = 0;
    bit ic_cool     = 0;
    bit dc_cool     = 0;
    bit prev_ic_rdy = 0;
    bit prev_dc_rdy = 0;

    task automatic checkOutput(input string tag, input logic [LANE-1:0] got, input logic [LANE-1:0] exp);
        vec_count++;
        if (got !== exp) begin
            miss_count++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [LANE-1:0] memRead(input logic [ADDR-1:0] a);
        if (mem.exists(a)) return mem[a];
        return {~a, a ^ 32'h5A5A_5A5A, a + 32'h0000_1357, a};
    endfunction

    // Advance the model across one rising edge using the inputs now driven.
    task automatic modelStep();
        mem_op_t op;
        if (rst_i) begin
            m_busy = 0; m_resp = 0; m_last = 0; m_err = 0; m_wait = 0;
            m_ops.delete();
        end else if (m_resp) begin
            m_resp = 0; m_busy = 0;
        end else if (m_busy) begin
            if (mem_ack_i) begin
                op = m_ops.pop_front();
                if (op.we) mem[op.addr] = op.data;
                else       m_data = memRead(op.addr);
                m_wait = 0;
                if (m_ops.size() == 0) m_resp = 1;
            end else begin
                if (m_wait < TMO) m_wait++;
                if (m_wait == TMO) m_err = 1;
            end
        end else if (ic_miss_i || dc_miss_i) begin
            m_who  = dc_miss_i && (!ic_miss_i || m_last == 0);
            m_last = m_who;
            m_busy = 1;
            m_wait = 0;
            if (m_who) begin
                m_fill = dc_addr_i & ALIGN;
                if (dc_writeback_i) m_ops.push_back('{1'b1, dc_wb_addr_i & ALIGN, dc_wb_data_i});
            end else begin
                m_fill = ic_addr_i & ALIGN;
            end
            m_ops.push_back('{1'b0, m_fill, '0});
        end
    endtask

    task automatic compareCycle();
        bit exp_req;
        exp_req = m_busy && !m_resp;
        checkOutput("mem_req", mem_req_o, exp_req);
        if (exp_req && m_ops.size() > 0) begin
            checkOutput("mem_we", mem_we_o, m_ops[0].we);
            checkOutput("mem_addr", mem_addr_o, m_ops[0].addr);
            if (m_ops[0].we) checkOutput("mem_data", mem_data_o, m_ops[0].data);
        end
        checkOutput("ic_rdy", ic_rdy_o, m_resp && !m_who);
        checkOutput("dc_rdy", dc_rdy_o, m_resp && m_who);
        if (m_resp && !m_who) begin
            checkOutput("ic_addr", ic_addr_o, m_fill);
            checkOutput("ic_data", ic_data_o, m_data);
        end
        if (m_resp && m_who) begin
            checkOutput("dc_addr", dc_addr_o, m_fill);
            checkOutput("dc_data", dc_data_o, m_data);
        end
        checkOutput("busy", busy_o, m_busy);
        checkOutput("err", err_o, m_err);
        checkOutput("ic_rdy_b2b", ic_rdy_o & prev_ic_rdy, 1'b0);
        checkOutput("dc_rdy_b2b", dc_rdy_o & prev_dc_rdy, 1'b0);
        prev_ic_rdy = ic_rdy_o;
        prev_dc_rdy = dc_rdy_o;
    endtask

    // Drive one cycle of inputs, step the model, then check after the edge.
    task automatic applyStimulus();
        if (random_mode) begin
            if (!ic_miss_i) begin
                if (ic_cool) ic_cool = 0;
                else if ($urandom_range(1, 100) <= ic_pct) ic_miss_i = 1'b1;
            end
            if (!dc_miss_i) begin
                if (dc_cool) dc_cool = 0;
                else if ($urandom_range(1, 100) <= dc_pct) dc_miss_i = 1'b1;
            end
            ic_addr_i      = $urandom;
            dc_addr_i      = $urandom;
            dc_writeback_i = 1'($urandom_range(0, 1));
            dc_wb_addr_i   = $urandom;
            dc_wb_data_i   = {$urandom, $urandom, $urandom, $urandom};
        end
        mem_ack_i  = mem_req_o && (ack_mode == 1 || (ack_mode == 2 && $urandom_range(0, 1) == 1));
        mem_data_i = memRead(mem_addr_o);
        modelStep();
        @(negedge clk_i);
        compareCycle();
        if (ic_rdy_o) begin ic_miss_i = 1'b0; ic_cool = 1; end
        if (dc_rdy_o) begin dc_miss_i = 1'b0; dc_cool = 1; end
    endtask

    task automatic doReset();
        rst_i = 1'b1;
        mem_ack_i = 1'b0;
        ic_miss_i = 1'b0;
        dc_miss_i = 1'b0;
        repeat (2) applyStimulus();
        rst_i = 1'b0;
    endtask

    initial begin
        $display("[TB] start");
        doReset();
        checkOutput("reset_busy", busy_o, 1'b0);
        checkOutput("reset_addr", mem_addr_o, 32'h0);

        // Icache only, ack in the first request cycle.
        ack_mode = 1;
        ic_miss_i = 1'b1; ic_addr_i = 32'h0000_1234;
        applyStimulus();
        checkOutput("d1_addr", mem_addr_o, 32'h0000_1230);
        checkOutput("d1_we", mem_we_o, 1'b0);
        applyStimulus();
        checkOutput("d1_rdy", ic_rdy_o, 1'b1);
        applyStimulus();

        // Dcache miss with dirty victim.
        dc_miss_i = 1'b1; dc_addr_i = 32'h0000_2000;
        dc_writeback_i = 1'b1; dc_wb_addr_i = 32'h0000_0080;
        dc_wb_data_i = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE;
        applyStimulus();
        checkOutput("d2_wb_we", mem_we_o, 1'b1);
        checkOutput("d2_wb_addr", mem_addr_o, 32'h0000_0080);
        checkOutput("d2_wb_data", mem_data_o, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE);
        applyStimulus();
        checkOutput("d2_rd_addr", mem_addr_o, 32'h0000_2000);
        applyStimulus();
        checkOutput("d2_rdy", dc_rdy_o, 1'b1);
        dc_writeback_i = 1'b0;
        applyStimulus();

        // Both requesters right after reset: dcache first, icache next.
        doReset();
        ic_miss_i = 1'b1; ic_addr_i = 32'h0000_3004;
        dc_miss_i = 1'b1; dc_addr_i = 32'h0000_4008;
        applyStimulus();
        checkOutput("d3_first", mem_addr_o, 32'h0000_4000);
        applyStimulus();
        applyStimulus();
        applyStimulus();
        checkOutput("d3_second", mem_addr_o, 32'h0000_3000);
        repeat (3) applyStimulus();

        // Reset in the middle of a read.
        ack_mode = 0;
        ic_miss_i = 1'b1; ic_addr_i = 32'h0000_6010;
        repeat (3) applyStimulus();
        rst_i = 1'b1;
        applyStimulus();
        checkOutput("rst_mid_req", mem_req_o, 1'b0);
        checkOutput("rst_mid_rdy", ic_rdy_o, 1'b0);
        rst_i = 1'b0;
        ack_mode = 1;
        repeat (4) applyStimulus();

        // Back-to-back icache misses with immediate ack.
        random_mode = 1; ic_pct = 100; dc_pct = 0;
        repeat (20) applyStimulus();

        // Random traffic from both caches.
        ack_mode = 2; ic_pct = 40; dc_pct = 40;
        repeat (2000) applyStimulus();

        // Drain, then a withheld ack long enough to trip the timeout.
        random_mode = 0; ack_mode = 1;
        repeat (12) applyStimulus();
        ack_mode = 0;
        ic_miss_i = 1'b1; ic_addr_i = 32'h0000_7777;
        repeat (300) applyStimulus();
        checkOutput("tmo_err", err_o, 1'b1);
        ack_mode = 1;
        repeat (3) applyStimulus();
        checkOutput("tmo_sticky", err_o, 1'b1);
        doReset();
        checkOutput("tmo_cleared", err_o, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
